// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - byte producer handshake bundle for the shared UART transmitter
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin shared 8N1-style UART transmitter driven by an oversampling tick
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick16,
  uart_tx_scheduler_if.slave    req,
  output logic                  tx,
  output logic                  busy,
  output logic [GW-1:0]         grant_id
);
  localparam int TW = $clog2(OVERSAMPLE*STOP_BITS) + 1;
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(OVERSAMPLE*STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [GW-1:0] PTR_LAST  = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [GW-1:0]     ptr;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [GW-1:0]     winner;
  logic              found;
  logic              accept;
  int                idx;

  // Search upward from the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req.req_valid[GW'(idx)]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  assign accept        = rst_n && (state == IDLE) && found;
  assign req.req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= req.req_data[winner*DATA_W +: DATA_W];
            grant_id <= winner;
            ptr      <= (winner == PTR_LAST) ? '0 : winner + 1'b1;
            tick_cnt <= '0;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (tick16) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= DATA;
              tx       <= shreg[0];
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick16) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              if (bit_idx == BIT_LAST) begin
                bit_idx <= '0;
                state   <= STOP;
                tx      <= 1'b1;
              end else begin
                // Present the next bit in the same edge as the shift so tx stays registered.
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
                tx      <= shreg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick16) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
